// File: rtl/tl_pkg.sv
// Shared definitions for the T-intersection signal path.
//   RED/YEL/GRN : 3-bit lamp codes {red,yellow,green}
//   state_t     : lamp monitor operating states
//   is_go()     : true when a code grants right-of-way (yellow or green)
package tl_pkg;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    NORMAL  = 2'd1,
    FLASH   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  function automatic logic is_go(input logic [2:0] c);
    return (c == YEL) || (c == GRN);
  endfunction
endpackage

// File: rtl/tl_conflict_check.sv
// Combinational sanity check of the four approach codes.
//   ls, br, lr, rb : controller light codes
//   invalid        : some code is not exactly one-hot
//   conflict       : right-of-way granted to incompatible approaches
//                    (legal go-sets: subsets of {LS,RB}, {LS,LR}, {BR})
module tl_conflict_check
  import tl_pkg::*;
(
  input  logic [2:0] ls,
  input  logic [2:0] br,
  input  logic [2:0] lr,
  input  logic [2:0] rb,
  output logic       invalid,
  output logic       conflict
);
  function automatic logic onehot3(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  assign invalid  = !(onehot3(ls) && onehot3(br) && onehot3(lr) && onehot3(rb));
  assign conflict = (is_go(br) && (is_go(ls) || is_go(lr) || is_go(rb))) ||
                    (is_go(lr) && is_go(rb));
endmodule

// File: rtl/signal_lamp_monitor.sv
// Safety stage between the phase controller and the lamp drivers.
// Registers the four light codes to the lamps, holds all-red at startup and
// after a fault clear, and latches a flashing-red fail-safe on filtered
// invalid/conflicting codes.
//   clk, rst               : clock, async active-high reset
//   light_*_in             : controller codes per approach
//   clear_fault            : request to leave FLASH (honoured only if inputs good)
//   lamp_*                 : registered lamp drive
//   fault                  : high while in FLASH
//   fault_code             : {conflict, invalid} latched at fault entry
module signal_lamp_monitor
  import tl_pkg::*;
#(
  parameter int FILTER_CYC  = 2,
  parameter int STARTUP_CYC = 4,
  parameter int FLASH_HALF  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_LS_in,
  input  logic [2:0] light_BR_in,
  input  logic [2:0] light_LR_in,
  input  logic [2:0] light_RB_in,
  input  logic       clear_fault,
  output logic [2:0] lamp_LS,
  output logic [2:0] lamp_BR,
  output logic [2:0] lamp_LR,
  output logic [2:0] lamp_RB,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int MAXP = (FILTER_CYC > STARTUP_CYC) ?
                        ((FILTER_CYC  > FLASH_HALF) ? FILTER_CYC  : FLASH_HALF) :
                        ((STARTUP_CYC > FLASH_HALF) ? STARTUP_CYC : FLASH_HALF);
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] F_MAX  = CW'(FILTER_CYC);
  localparam logic [CW-1:0] F_LAST = CW'(FILTER_CYC - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] H_LAST = CW'(FLASH_HALF - 1);
  localparam logic [11:0]   ALL_RED = {4{RED}};

  state_t        state, state_nx;
  logic [CW-1:0] scnt, scnt_nx;   // startup / recover hold
  logic [CW-1:0] fcnt, fcnt_nx;   // consecutive bad cycles
  logic [CW-1:0] hcnt, hcnt_nx;   // flash half-period
  logic          phase, phase_nx;
  logic [11:0]   lamps, lamps_nx;
  logic [1:0]    code_nx;
  logic          invalid, conflict, bad, latch;
  logic [11:0]   lights;

  assign lights = {light_LS_in, light_BR_in, light_LR_in, light_RB_in};

  tl_conflict_check u_chk (
    .ls       (light_LS_in),
    .br       (light_BR_in),
    .lr       (light_LR_in),
    .rb       (light_RB_in),
    .invalid  (invalid),
    .conflict (conflict)
  );

  assign bad   = invalid | conflict;
  assign latch = bad && (fcnt == F_LAST);

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    fcnt_nx  = bad ? ((fcnt == F_MAX) ? fcnt : fcnt + ONE) : '0;
    hcnt_nx  = hcnt;
    phase_nx = phase;
    code_nx  = fault_code;
    lamps_nx = ALL_RED;
    case (state)
      STARTUP: begin
        fcnt_nx = '0;
        if (scnt >= S_LAST) begin
          state_nx = NORMAL;
          scnt_nx  = '0;
        end else begin
          scnt_nx = scnt + ONE;
        end
      end
      NORMAL: begin
        if (latch) begin
          // The latching cycle counts as the first red cycle of the flash.
          state_nx = FLASH;
          code_nx  = {conflict, invalid};
          phase_nx = 1'b1;
          hcnt_nx  = ONE;
        end else begin
          lamps_nx = lights;
        end
      end
      FLASH: begin
        lamps_nx = {4{phase, 2'b00}};
        if (hcnt >= H_LAST) begin
          hcnt_nx  = '0;
          phase_nx = ~phase;
        end else begin
          hcnt_nx = hcnt + ONE;
        end
        if (clear_fault && !bad) begin
          state_nx = RECOVER;
          code_nx  = 2'b00;
          scnt_nx  = '0;
        end
      end
      RECOVER: begin
        if (latch) begin
          state_nx = FLASH;
          code_nx  = {conflict, invalid};
          phase_nx = 1'b1;
          hcnt_nx  = ONE;
        end else if (scnt >= S_LAST) begin
          state_nx = NORMAL;
          scnt_nx  = '0;
        end else begin
          scnt_nx = scnt + ONE;
        end
      end
      default: begin
        state_nx = FLASH;
        code_nx  = 2'b11;
        phase_nx = 1'b1;
        hcnt_nx  = ONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STARTUP;
      scnt       <= '0;
      fcnt       <= '0;
      hcnt       <= '0;
      phase      <= 1'b1;
      lamps      <= ALL_RED;
      fault_code <= 2'b00;
    end else begin
      state      <= state_nx;
      scnt       <= scnt_nx;
      fcnt       <= fcnt_nx;
      hcnt       <= hcnt_nx;
      phase      <= phase_nx;
      lamps      <= lamps_nx;
      fault_code <= code_nx;
    end
  end

  assign {lamp_LS, lamp_BR, lamp_LR, lamp_RB} = lamps;
  assign fault = (state == FLASH);
endmodule

// File: tb/tb_signal_lamp_monitor.sv
// Self-checking bench for signal_lamp_monitor: directed table, hand-written
// corner sequences, a controller replay and random stimulus, all against a
// behavioural reference model.
module tb_signal_lamp_monitor;
  import tl_pkg::*;

  localparam int FILT = 2;
  localparam int SCYC = 4;
  localparam int HALF = 3;

  localparam logic [11:0] R4  = {RED, RED, RED, RED};
  localparam logic [11:0] OFF = 12'b0;
  localparam logic [11:0] P   = {GRN, RED, RED, GRN};   // LS+RB go
  localparam logic [11:0] G   = {GRN, GRN, RED, RED};   // LS+BR conflict
  localparam logic [11:0] B4  = {GRN, RED, 3'b011, RED}; // LR invalid

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] ls, br, lr, rb;
  logic clr;
  logic [2:0] lamp_LS, lamp_BR, lamp_LR, lamp_RB;
  logic fault;
  logic [1:0] fault_code;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  signal_lamp_monitor #(.FILTER_CYC(FILT), .STARTUP_CYC(SCYC), .FLASH_HALF(HALF)) dut (
    .clk(clk), .rst(rst),
    .light_LS_in(ls), .light_BR_in(br), .light_LR_in(lr), .light_RB_in(rb),
    .clear_fault(clr),
    .lamp_LS(lamp_LS), .lamp_BR(lamp_BR), .lamp_LR(lamp_LR), .lamp_RB(lamp_RB),
    .fault(fault), .fault_code(fault_code)
  );

  // ---------------- reference model ----------------
  int         m_hold, m_run, m_k;
  bit         m_startup, m_flash;
  logic [1:0] m_code;
  logic [11:0] m_lamps;

  function automatic bit g(input logic [2:0] c);
    return ($countones(c) == 1) && (c != RED);
  endfunction

  task automatic m_reset();
    m_hold = SCYC; m_startup = 1; m_flash = 0; m_run = 0; m_k = 0;
    m_code = 2'b00; m_lamps = R4;
  endtask

  task automatic m_step(input logic [11:0] in, input logic c);
    logic [3:0] s;
    bit inv, con, bad, lat;
    inv = ($countones(in[11:9]) != 1) || ($countones(in[8:6]) != 1) ||
          ($countones(in[5:3]) != 1) || ($countones(in[2:0]) != 1);
    s = {g(in[11:9]), g(in[8:6]), g(in[5:3]), g(in[2:0])};
    con = !(((s & ~4'b1001) == 0) || ((s & ~4'b1010) == 0) || ((s & ~4'b0100) == 0));
    bad = inv || con;
    lat = !m_startup && !m_flash && bad && (m_run == FILT - 1);
    if (m_startup) m_run = 0;
    else m_run = bad ? ((m_run < FILT) ? m_run + 1 : FILT) : 0;
    if (m_flash) begin
      m_k++;
      m_lamps = (((m_k / HALF) % 2) == 0) ? R4 : OFF;
      if (c && !bad) begin
        m_flash = 0; m_code = 2'b00; m_hold = SCYC;
      end
    end else if (lat) begin
      m_flash = 1; m_k = 0; m_lamps = R4; m_code = {con, inv}; m_hold = 0;
    end else if (m_hold > 0) begin
      m_lamps = R4;
      m_hold--;
      if (m_hold == 0) m_startup = 0;
    end else begin
      m_lamps = in;
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [14:0] dut_vec();
    return {lamp_LS, lamp_BR, lamp_LR, lamp_RB, fault, fault_code};
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got lamps=%b fault=%b code=%b, expected lamps=%b fault=%b code=%b",
               nm, $time, act[14:3], act[2], act[1:0], exp[14:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic cyc(input logic [11:0] in, input logic c, input string nm);
    {ls, br, lr, rb} = in;
    clr = c;
    @(posedge clk);
    m_step(in, c);
    #1;
    chk(nm, dut_vec(), {m_lamps, m_flash, m_code});
  endtask

  task automatic do_reset();
    {ls, br, lr, rb} = P;
    clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset", dut_vec(), {R4, 1'b0, 2'b00});
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [11:0] in;
    logic        clr;
    logic [11:0] lamps;
    logic        fault;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl[$];
  logic [11:0] pool[7];
  logic [11:0] rin;

  initial begin
    // Directed table: startup hold, pass-through, glitch, latch, flash, clear.
    for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{P, 1'b0, R4, 1'b0, 2'b00});
    tbl.push_back(vec_t'{P, 1'b0, P,   1'b0, 2'b00});
    tbl.push_back(vec_t'{P, 1'b0, P,   1'b0, 2'b00});
    tbl.push_back(vec_t'{G, 1'b0, G,   1'b0, 2'b00}); // single-cycle glitch
    tbl.push_back(vec_t'{P, 1'b0, P,   1'b0, 2'b00});
    tbl.push_back(vec_t'{G, 1'b0, G,   1'b0, 2'b00});
    tbl.push_back(vec_t'{G, 1'b0, R4,  1'b1, 2'b10}); // latch
    tbl.push_back(vec_t'{G, 1'b0, R4,  1'b1, 2'b10});
    tbl.push_back(vec_t'{G, 1'b0, R4,  1'b1, 2'b10});
    for (int i = 0; i < 3; i++) tbl.push_back(vec_t'{P, 1'b0, OFF, 1'b1, 2'b10});
    tbl.push_back(vec_t'{P, 1'b0, R4,  1'b1, 2'b10});
    tbl.push_back(vec_t'{P, 1'b1, R4,  1'b0, 2'b00}); // clear accepted
    for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{P, 1'b0, R4, 1'b0, 2'b00});
    tbl.push_back(vec_t'{P, 1'b0, P,   1'b0, 2'b00});

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].clr, "tbl_model");
      chk("tbl", dut_vec(), {tbl[i].lamps, tbl[i].fault, tbl[i].code});
    end

    // clear_fault outside FLASH has no effect
    cyc(P, 1'b1, "clr_normal");
    chk("clr_normal_const", dut_vec(), {P, 1'b0, 2'b00});

    // Invalid code held two cycles, clear ignored while bad, then real clear.
    cyc(B4, 1'b0, "inv1");
    cyc(B4, 1'b0, "inv2");
    chk("inv_latch", dut_vec(), {R4, 1'b1, 2'b01});
    cyc(G, 1'b0, "new_fault_in_flash");
    cyc(G, 1'b0, "new_fault_in_flash2");
    chk("code_kept", {12'b0, fault, fault_code}, {12'b0, 1'b1, 2'b01});
    cyc(B4, 1'b1, "clr_while_bad");
    chk("clr_ignored", {12'b0, fault, fault_code}, {12'b0, 1'b1, 2'b01});
    cyc(P, 1'b1, "clr_ok");
    chk("clr_ok_const", {12'b0, fault, fault_code}, {12'b0, 1'b0, 2'b00});
    for (int i = 0; i < 4; i++) begin
      cyc(P, 1'b0, "recover");
      chk("recover_red", dut_vec(), {R4, 1'b0, 2'b00});
    end
    cyc(P, 1'b0, "after_recover");
    chk("after_recover_pass", dut_vec(), {P, 1'b0, 2'b00});

    // Async reset mid-FLASH
    cyc(G, 1'b0, "pre_rst1");
    cyc(G, 1'b0, "pre_rst2");
    cyc(G, 1'b0, "pre_rst3");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", dut_vec(), {R4, 1'b0, 2'b00});
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    // Full controller cycle, twice: 8/3/6/3/4/3
    pool[0] = {GRN, RED, RED, GRN};
    pool[1] = {YEL, RED, RED, YEL};
    pool[2] = {GRN, RED, GRN, RED};
    pool[3] = {YEL, RED, YEL, RED};
    pool[4] = {RED, GRN, RED, RED};
    pool[5] = {RED, YEL, RED, RED};
    pool[6] = R4;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) cyc(pool[0], 1'b0, "ctl_A");
      for (int i = 0; i < 3; i++) cyc(pool[1], 1'b0, "ctl_Ay");
      for (int i = 0; i < 6; i++) cyc(pool[2], 1'b0, "ctl_B");
      for (int i = 0; i < 3; i++) cyc(pool[3], 1'b0, "ctl_By");
      for (int i = 0; i < 4; i++) cyc(pool[4], 1'b0, "ctl_C");
      for (int i = 0; i < 3; i++) cyc(pool[5], 1'b0, "ctl_Cy");
    end
    chk("ctl_no_fault", {12'b0, fault, fault_code}, {12'b0, 1'b0, 2'b00});

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        rin = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      else if ($urandom_range(0, 11) == 0)
        rin = G;
      else
        rin = pool[$urandom_range(0, 6)];
      cyc(rin, ($urandom_range(0, 5) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
